// File: rtl/vga_pkg.sv
// Shared types and helpers for the tile renderer: directions, connection masks, colours, bands, fill states.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package vga_pkg;

    // Direction toward the next streamed segment.
    typedef logic [1:0] dir_t;
    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    // Connection mask: bit 0 top, 1 bottom, 2 left, 3 right (same encoding as dir_t).
    typedef logic [3:0] conn_mask_t;

    typedef logic [1:0] color_t;

    typedef enum logic [1:0] {LO, MID, HI} band_t;

    typedef enum logic [1:0] {SYNC, FILL, DONE} fill_state_t;

    // Up<->down and left<->right differ only in the low bit.
    function automatic dir_t opposite(input dir_t d);
        return {d[1], ~d[0]};
    endfunction

    function automatic conn_mask_t dir_bit(input dir_t d);
        conn_mask_t m;
        m    = '0;
        m[d] = 1'b1;
        return m;
    endfunction

    // Returns {r[1:0], g[1:0], b[1:0]}.
    function automatic logic [5:0] palette(input color_t c, input logic colorblind);
        logic [5:0] rgb;
        case (c)
            2'd0:    rgb = 6'b000000;
            2'd1:    rgb = colorblind ? 6'b000011 : 6'b001100;
            2'd2:    rgb = 6'b110000;
            default: rgb = 6'b111111;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_row_buffer.sv
// Ping-pong row storage: front bank read combinationally, back bank OR-written; swap exchanges roles and clears the new back.
// Latency: read is combinational; a write is visible in the front bank after the next swap.
// Backpressure: none; the caller must not write in a swap cycle (the swap clear takes precedence).
//
// Ports: clk, rst (sync, active-high, clears both banks); swap; wr_en/wr_idx/wr_mask (OR-write to back);
//        rd_idx/rd_mask (front bank read, 0 for out-of-range index).
module vga_row_buffer
    import vga_pkg::*;
#(
    parameter int DEPTH = 20,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swap,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_idx,
    input  conn_mask_t        wr_mask,
    input  logic [AW-1:0]     rd_idx,
    output conn_mask_t        rd_mask
);

    logic [DEPTH-1:0][3:0] bank [2];
    logic                  front_sel;
    logic                  back_sel;

    assign back_sel = ~front_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            bank[0]   <= '0;
            bank[1]   <= '0;
            front_sel <= 1'b0;
        end else if (swap) begin
            // The old front becomes the new back and starts empty.
            front_sel        <= back_sel;
            bank[front_sel]  <= '0;
        end else if (wr_en && (int'(wr_idx) < DEPTH)) begin
            bank[back_sel][wr_idx] <= bank[back_sel][wr_idx] | wr_mask;
        end
    end

    assign rd_mask = (int'(rd_idx) < DEPTH) ? bank[front_sel][rd_idx] : '0;

endmodule

// File: rtl/vga_tile_renderer.sv
// Tile renderer: turns streamed snake segments and apples into 2-bit RGB for 640x480, with eat-flash border.
// Latency: 1 cycle from px/py/hsync_in/vsync_in to r/g/b/hsync/vsync (syncs stay pixel-aligned).
// Backpressure: seg_ready is low only in reset and in the swap cycle; segments are otherwise always consumed.
//
// Ports: clk, rst; px/py/visible/hsync_in/vsync_in from vga_sync; seg_valid/seg_ready/seg_x/seg_y/seg_dir/
//        seg_first/seg_last segment stream; apple_x/apple_y/apple_valid packed apples; failure/success/eat/
//        colorblind status; r/g/b/hsync/vsync to pins; row_overrun one-cycle pulse on an unfinished row.
// EDGE must satisfy 0 < EDGE < 2^(TILE_LOG2-1).
module vga_tile_renderer
    import vga_pkg::*;
#(
    parameter int GRID_W       = 18,
    parameter int GRID_H       = 13,
    parameter int TILE_LOG2    = 5,
    parameter int EDGE         = 4,
    parameter int N_APPLES     = 2,
    parameter int FLASH_FRAMES = 8,
    localparam int XW          = $clog2(GRID_W + 2),
    localparam int YW          = $clog2(GRID_H + 2)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             px,
    input  logic [9:0]             py,
    input  logic                   visible,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   seg_valid,
    output logic                   seg_ready,
    input  logic [XW-1:0]          seg_x,
    input  logic [YW-1:0]          seg_y,
    input  logic [1:0]             seg_dir,
    input  logic                   seg_first,
    input  logic                   seg_last,
    input  logic [N_APPLES*XW-1:0] apple_x,
    input  logic [N_APPLES*YW-1:0] apple_y,
    input  logic [N_APPLES-1:0]    apple_valid,
    input  logic                   failure,
    input  logic                   success,
    input  logic                   eat,
    input  logic                   colorblind,
    output logic [1:0]             r,
    output logic [1:0]             g,
    output logic [1:0]             b,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   row_overrun
);

    localparam int TW = 10 - TILE_LOG2;
    localparam int FW = $clog2(FLASH_FRAMES + 1);

    // ---------------- geometry ----------------
    logic [TW-1:0]        tx, ty;
    logic [TILE_LOG2-1:0] ox, oy;
    logic [YW-1:0]        target_row;
    logic                 swap, frame_tick;
    band_t                bx, by;

    assign tx = px[9:TILE_LOG2];
    assign ty = py[9:TILE_LOG2];
    assign ox = px[TILE_LOG2-1:0];
    assign oy = py[TILE_LOG2-1:0];

    // The back bank always collects the row below the one being displayed.
    assign target_row = YW'({1'b0, ty} + 1'b1);

    assign swap       = (px == '0) && (oy == '0);
    assign frame_tick = (px == '0) && (py == '0);

    function automatic band_t band_of(input logic [TILE_LOG2-1:0] o);
        if (int'(o) < EDGE)                          return LO;
        else if (int'(o) >= (1 << TILE_LOG2) - EDGE) return HI;
        else                                         return MID;
    endfunction

    assign bx = band_of(ox);
    assign by = band_of(oy);

    // ---------------- segment fill FSM ----------------
    fill_state_t state_q, state_d;
    dir_t        prev_dir;
    logic        xfer, process, wr_en;
    conn_mask_t  seg_mask;

    assign seg_ready = !rst && !swap;
    assign xfer      = seg_valid && seg_ready;

    always_comb begin
        state_d = state_q;
        process = 1'b0;
        case (state_q)
            SYNC: begin
                // Wait for the head so a row never starts mid-list.
                if (xfer && seg_first) begin
                    process = 1'b1;
                    state_d = seg_last ? DONE : FILL;
                end
            end
            FILL: begin
                if (xfer) begin
                    process = 1'b1;
                    if (seg_last) state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = SYNC;
        endcase
        if (swap) state_d = SYNC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SYNC;
            prev_dir <= DIR_UP;
        end else begin
            state_q <= state_d;
            // Tracks every consumed segment, dropped ones included, so the chain stays coherent.
            if (xfer) prev_dir <= seg_dir;
        end
    end

    assign seg_mask = (seg_last  ? conn_mask_t'(0) : dir_bit(seg_dir))
                    | (seg_first ? conn_mask_t'(0) : dir_bit(opposite(prev_dir)));

    assign wr_en = process && (seg_y == target_row)
                && (seg_x >= XW'(1)) && (seg_x <= XW'(GRID_W));

    assign row_overrun = swap && !rst && (state_q != DONE);

    // ---------------- row storage ----------------
    conn_mask_t rd_mask, front_mask;
    logic       tx_ok;

    vga_row_buffer #(
        .DEPTH (GRID_W + 2),
        .AW    (XW)
    ) u_row_buffer (
        .clk     (clk),
        .rst     (rst),
        .swap    (swap),
        .wr_en   (wr_en),
        .wr_idx  (seg_x),
        .wr_mask (seg_mask),
        .rd_idx  (XW'(tx)),
        .rd_mask (rd_mask)
    );

    assign tx_ok      = int'(tx) <= GRID_W + 1;
    assign front_mask = tx_ok ? rd_mask : '0;

    // ---------------- flash counter ----------------
    logic [FW-1:0] flash_cnt;

    always_ff @(posedge clk) begin
        if (rst)                              flash_cnt <= '0;
        else if (eat)                         flash_cnt <= FW'(FLASH_FRAMES);
        else if (frame_tick && flash_cnt != 0) flash_cnt <= flash_cnt - 1'b1;
    end

    // ---------------- colour selection ----------------
    logic   apple_hit, border;
    color_t color;

    always_comb begin
        apple_hit = 1'b0;
        for (int i = 0; i < N_APPLES; i++) begin
            if (apple_valid[i]
                && int'(apple_x[i*XW +: XW]) == int'(tx)
                && int'(apple_y[i*YW +: YW]) == int'(ty))
                apple_hit = 1'b1;
        end
    end

    assign border = (tx == '0) || (int'(tx) == GRID_W + 1)
                 || (ty == '0) || (int'(ty) == GRID_H + 1);

    always_comb begin
        color = 2'd0;
        if (!visible) begin
            color = 2'd0;
        end else if (border) begin
            if ({success, failure} == 2'b10)      color = 2'd1;
            else if ({success, failure} == 2'b01) color = 2'd2;
            else if (flash_cnt != 0)              color = 2'd1;
            else                                  color = 2'd3;
        end else if (bx == MID && by == MID) begin
            if (front_mask != 0) color = 2'd1;
            else if (apple_hit)  color = 2'd2;
        end else if ((bx == MID && by == LO  && front_mask[0])
                  || (bx == MID && by == HI  && front_mask[1])
                  || (bx == LO  && by == MID && front_mask[2])
                  || (bx == HI  && by == MID && front_mask[3])) begin
            color = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {r, g, b} <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
        end else begin
            {r, g, b} <= palette(color, colorblind);
            hsync     <= hsync_in;
            vsync     <= vsync_in;
        end
    end

endmodule

// File: tb/tb_vga_tile_renderer.sv
module tb_vga_tile_renderer;

    localparam logic [5:0] C0   = 6'b000000;
    localparam logic [5:0] C1   = 6'b001100;
    localparam logic [5:0] C1CB = 6'b000011;
    localparam logic [5:0] C2   = 6'b110000;
    localparam logic [5:0] C3   = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] px, py;
    logic       visible, hsync_in, vsync_in;
    logic       seg_valid, seg_ready, seg_first, seg_last;
    logic [4:0] seg_x;
    logic [3:0] seg_y;
    logic [1:0] seg_dir;
    logic [9:0] apple_x;
    logic [7:0] apple_y;
    logic [1:0] apple_valid;
    logic       failure, success, eat, colorblind;
    logic [1:0] r, g, b;
    logic       hsync, vsync, row_overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_tile_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .px          (px),
        .py          (py),
        .visible     (visible),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .seg_valid   (seg_valid),
        .seg_ready   (seg_ready),
        .seg_x       (seg_x),
        .seg_y       (seg_y),
        .seg_dir     (seg_dir),
        .seg_first   (seg_first),
        .seg_last    (seg_last),
        .apple_x     (apple_x),
        .apple_y     (apple_y),
        .apple_valid (apple_valid),
        .failure     (failure),
        .success     (success),
        .eat         (eat),
        .colorblind  (colorblind),
        .r           (r),
        .g           (g),
        .b           (b),
        .hsync       (hsync),
        .vsync       (vsync),
        .row_overrun (row_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one pixel and advance one clock; registered outputs are then valid for it.
    task automatic step(input int x, input int y);
        px = 10'(x);
        py = 10'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic [5:0] exp);
        step(x, y);
        chk(tag, {r, g, b}, exp);
    endtask

    // Offer one segment at px=1 (never a swap) on the current scanline.
    task automatic seg(input int x, input int y, input int d, input logic f, input logic l);
        px        = 10'd1;
        seg_x     = 5'(x);
        seg_y     = 4'(y);
        seg_dir   = 2'(d);
        seg_first = f;
        seg_last  = l;
        seg_valid = 1'b1;
        #1;
        chk("seg_ready", seg_ready, 1);
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
    endtask

    initial begin
        int pulses;
        rst = 1'b1; px = '0; py = 10'd100; visible = 1'b1;
        hsync_in = 1'b0; vsync_in = 1'b0;
        seg_valid = 1'b1; seg_x = '0; seg_y = '0; seg_dir = '0;
        seg_first = 1'b0; seg_last = 1'b0;
        apple_x = '0; apple_y = '0; apple_valid = '0;
        failure = 1'b0; success = 1'b0; eat = 1'b0; colorblind = 1'b0;

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", {r, g, b}, C0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_ready", seg_ready, 0);
        chk("rst_overrun", row_overrun, 0);
        rst = 1'b0; seg_valid = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;

        // ---- sync passthrough, one-cycle latency ----
        hsync_in = 1'b0; vsync_in = 1'b0;
        step(300, 100);
        chk("hsync_lo", hsync, 0);
        chk("vsync_lo", vsync, 0);
        hsync_in = 1'b1; vsync_in = 1'b1;
        step(301, 100);
        chk("hsync_hi", hsync, 1);

        // ---- straight snake on row 5, streamed during tile row 4 ----
        step(0, 128);
        seg(3, 5, 3, 1'b1, 1'b0);
        seg(4, 5, 3, 1'b0, 1'b0);
        seg(5, 5, 3, 1'b0, 1'b1);
        px = 10'd0; py = 10'd160; #1;
        chk("swap_done_no_overrun", row_overrun, 0);
        step(0, 160);
        pix("t3_centre",   112, 176, C1);
        pix("t3_left",      97, 176, C0);
        pix("t3_ox3_left",  99, 176, C0);
        pix("t3_ox4_mid",  100, 176, C1);
        pix("t3_ox28_rt",  124, 176, C1);
        pix("t4_left",     129, 176, C1);
        pix("t4_right",    158, 176, C1);
        pix("t4_top",      144, 161, C0);
        pix("t5_left",     161, 176, C1);
        pix("t5_right",    190, 176, C0);
        visible = 1'b0;
        pix("not_visible", 112, 176, C0);
        visible = 1'b1;

        // ---- apples ----
        apple_x = {5'd0, 5'd7}; apple_y = {4'd0, 4'd2}; apple_valid = 2'b01;
        pix("apple0_on", 240, 80, C2);
        apple_valid = 2'b00;
        pix("apple0_off", 240, 80, C0);
        apple_x = {5'd7, 5'd0}; apple_y = {4'd2, 4'd0}; apple_valid = 2'b10;
        pix("apple1_on", 240, 80, C2);
        apple_valid = 2'b01;
        pix("apple0_elsewhere", 240, 80, C0);
        apple_valid = 2'b00;

        // ---- self-overlap at tile (4,6), streamed during tile row 5 ----
        py = 10'd160;
        seg(3, 6, 3, 1'b1, 1'b0);
        seg(4, 6, 1, 1'b0, 1'b0);
        seg(4, 5, 1, 1'b0, 1'b0);
        seg(4, 6, 3, 1'b0, 1'b0);
        seg(5, 6, 0, 1'b0, 1'b1);
        step(0, 192);
        pix("ov_centre", 144, 208, C1);
        pix("ov_left",   129, 208, C1);
        pix("ov_right",  158, 208, C1);
        pix("ov_top",    144, 193, C1);
        pix("ov_bottom", 144, 222, C1);
        pix("ov_corner", 129, 193, C0);
        pix("ov_t3_left", 97, 208, C0);
        pix("ov_t5_right", 190, 208, C0);

        // ---- overrun: seg_last withheld past the swap ----
        py = 10'd192;
        seg(2, 7, 3, 1'b1, 1'b0);
        pulses = 0;
        seg_valid = 1'b1; seg_first = 1'b0; seg_last = 1'b1;
        px = 10'd0; py = 10'd224; #1;
        chk("overrun_ready0", seg_ready, 0);
        if (row_overrun) pulses++;
        for (int k = 1; k < 5; k++) begin
            @(posedge clk); #1;
            px = 10'(k); #1;
            if (row_overrun) pulses++;
        end
        seg_valid = 1'b0;
        chk("overrun_pulses", pulses, 1);
        pix("partial_centre", 80, 240, C1);
        pix("partial_right",  94, 240, C1);

        // ---- border and flash ----
        pix("border_idle", 16, 16, C3);
        eat = 1'b1;
        step(5, 5);
        eat = 1'b0;
        pix("flash_start", 16, 16, C1);
        for (int k = 0; k < 7; k++) step(0, 0);
        pix("flash_7ticks", 16, 16, C1);
        colorblind = 1'b1;
        pix("flash_cb", 16, 16, C1CB);
        colorblind = 1'b0;
        step(0, 0);
        pix("flash_over", 16, 16, C3);
        success = 1'b1;
        pix("border_success", 16, 16, C1);
        success = 1'b0; failure = 1'b1;
        pix("border_failure", 16, 16, C2);
        success = 1'b1;
        pix("border_both", 16, 16, C3);
        success = 1'b0; failure = 1'b0;
        eat = 1'b1;
        step(0, 0);
        eat = 1'b0;
        pix("eat_beats_tick", 624, 464, C1);
        for (int k = 0; k < 8; k++) step(0, 0);
        pix("eat_tick_over", 624, 464, C3);

        // ---- reset mid-fill ----
        step(0, 256);
        seg(3, 9, 3, 1'b1, 1'b0);
        rst = 1'b1; seg_valid = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        px = 10'd16; py = 10'd16; #1;
        chk("midrst_ready", seg_ready, 0);
        @(posedge clk); #1;
        chk("midrst_rgb", {r, g, b}, C0);
        chk("midrst_hsync", hsync, 1);
        chk("midrst_vsync", vsync, 1);
        chk("midrst_overrun", row_overrun, 0);
        rst = 1'b0; seg_valid = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        step(0, 288);
        pix("post_rst_centre", 112, 304, C0);
        pix("post_rst_right",  126, 304, C0);
        pix("post_rst_border", 16, 16, C3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
